// File: rtl/wishbone_ctrl_classic_pkg.sv
// Shared types for the Wishbone classic controller:
// response status, FSM states and counter sizing.
package wishbone_ctrl_classic_pkg;

    typedef enum logic [1:0] {
        WB_OK      = 2'd0,
        WB_ERR     = 2'd1,
        WB_TIMEOUT = 2'd2
    } wb_status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_ctrl_state_t;

    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/wishbone_classic.sv
// Wishbone classic bus bundle with controller and
// device views.
interface wishbone_classic #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_W-1:0]     adr;
    logic [DATA_W-1:0]     dat_w;
    logic [DATA_W-1:0]     dat_r;
    logic [DATA_W/8-1:0]   sel;
    logic                  ack;
    logic                  err;

    modport controller (
        output cyc, stb, we, adr, dat_w, sel,
        input  ack, err, dat_r
    );

    modport device (
        input  cyc, stb, we, adr, dat_w, sel,
        output ack, err, dat_r
    );
endinterface

// File: rtl/wishbone_ctrl_classic.sv
// Single-outstanding Wishbone classic initiator:
// one command in, one bus cycle, one response out.
module wishbone_ctrl_classic
    import wishbone_ctrl_classic_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output wb_status_t          rsp_status,
    wishbone_classic.controller wb
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT == 0) ? CNT_MAX : CNT_W'(TIMEOUT - 1);

    wb_ctrl_state_t        r_state, w_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic                  r_cmd_ready, w_cmd_ready;
    logic                  r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_dat, w_rsp_dat;
    wb_status_t            r_rsp_status, w_rsp_status;
    logic                  r_cyc, w_cyc;
    logic                  r_we, w_we;
    logic [ADDR_W-1:0]     r_adr, w_adr;
    logic [DATA_W-1:0]     r_dat, w_dat;
    logic [DATA_W/8-1:0]   r_sel, w_sel;
    logic                  w_to_hit;

    assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    // Next-state and registered-output decode
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_rsp_dat    = r_rsp_dat;
        w_rsp_status = r_rsp_status;
        w_cyc        = r_cyc;
        w_we         = r_we;
        w_adr        = r_adr;
        w_dat        = r_dat;
        w_sel        = r_sel;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_we    = cmd_we;
                    w_adr   = cmd_adr;
                    w_dat   = cmd_dat;
                    w_sel   = cmd_sel;
                    w_cyc   = 1'b1;
                    w_cnt   = '0;
                    w_state = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb.err) begin
                    w_rsp_status = WB_ERR;
                    w_rsp_dat    = '0;
                    w_cyc        = 1'b0;
                    w_state      = ST_RESP;
                end else if (wb.ack) begin
                    w_rsp_status = WB_OK;
                    w_rsp_dat    = r_we ? '0 : wb.dat_r;
                    w_cyc        = 1'b0;
                    w_state      = ST_RESP;
                end else if (w_to_hit) begin
                    w_rsp_status = WB_TIMEOUT;
                    w_rsp_dat    = '0;
                    w_cyc        = 1'b0;
                    w_state      = ST_RESP;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cyc   = 1'b0;
            end
        endcase
        w_cmd_ready = (w_state == ST_IDLE);
        w_rsp_valid = (w_state == ST_RESP);
    end

    // State, counter, bus and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= WB_OK;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_cmd_ready  <= w_cmd_ready;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_dat    <= w_rsp_dat;
            r_rsp_status <= w_rsp_status;
            r_cyc        <= w_cyc;
            r_we         <= w_we;
            r_adr        <= w_adr;
            r_dat        <= w_dat;
            r_sel        <= w_sel;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dat    = r_rsp_dat;
    assign rsp_status = r_rsp_status;
    assign wb.cyc     = r_cyc;
    assign wb.stb     = r_cyc;
    assign wb.we      = r_we;
    assign wb.adr     = r_adr;
    assign wb.dat_w   = r_dat;
    assign wb.sel     = r_sel;

`ifdef FORMAL
    a_cyc_stb: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        wb.cyc == wb.stb);

    a_bus_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_BUS && w_state == ST_BUS)
        |=> $stable({r_cyc, r_we, r_adr, r_dat, r_sel}));

    a_rsp_no_cyc: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        r_rsp_valid |-> !r_cyc);

    c_wr_then_rd: cover property (
        @(posedge clk_i) disable iff (!rst_ni)
        (cmd_valid && r_cmd_ready && cmd_we)
        ##[1:$] (cmd_valid && r_cmd_ready && !cmd_we));
`endif

endmodule

// File: tb/tb_wishbone_ctrl_classic.sv
// Scoreboard bench for the Wishbone classic controller
// against a configurable wait-state / error device.
module tb_wishbone_ctrl_classic;
    import wishbone_ctrl_classic_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [DW-1:0]   cmd_dat;
    logic [DW/8-1:0] cmd_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_dat;
    wb_status_t      rsp_status;

    wishbone_classic #(.ADDR_W(AW), .DATA_W(DW)) wb ();

    wishbone_ctrl_classic #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat),
        .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat),
        .rsp_status(rsp_status),
        .wb(wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device model: N wait states, optional never-ack,
    // optional ack+err on the 2nd bus cycle.
    int          dev_wait;
    bit          dev_never;
    bit          dev_err;
    logic [31:0] dev_rdata;
    logic [31:0] led;
    int          dev_cnt;
    logic        dev_act;

    assign dev_act = wb.cyc && wb.stb;
    assign wb.err = dev_act && dev_err && (dev_cnt == 1);
    assign wb.ack = dev_act && !dev_never &&
                    ((dev_cnt == dev_wait) ||
                     (dev_err && dev_cnt == 1));
    assign wb.dat_r = (dev_act && !wb.we) ? dev_rdata : 32'h0;

    function automatic logic [31:0] sel_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++)
            if (s[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_cnt <= 0;
            led     <= '0;
        end else begin
            if (dev_act && !(wb.ack || wb.err))
                dev_cnt <= dev_cnt + 1;
            else
                dev_cnt <= 0;
            if (dev_act && wb.we && wb.ack && !wb.err)
                led <= (led & ~sel_mask(wb.sel)) |
                       (wb.dat_w & sel_mask(wb.sel));
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h",
                     tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] dat;
        logic [31:0] status;
        logic [31:0] cycles;
    } exp_t;

    exp_t sb_q[$];
    int   cyc_cnt;

    // Scoreboard: pop on each response handshake;
    // also count cycles with cyc high per transaction.
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc_cnt = 0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_dat", rsp_dat, e.dat);
                    check("rsp_status", 32'(rsp_status), e.status);
                    check("cyc_cycles", cyc_cnt, e.cycles);
                end
                cyc_cnt = 0;
            end
            if (wb.cyc) cyc_cnt++;
        end
    end

    task automatic push(input logic [31:0] d,
                        input wb_status_t s,
                        input int c);
        exp_t e;
        e.dat = d;
        e.status = 32'(s);
        e.cycles = c;
        sb_q.push_back(e);
    endtask

    // Returns one time unit into cycle 1 after acceptance.
    task automatic send(input logic we,
                        input logic [31:0] adr,
                        input logic [31:0] dat,
                        input logic [3:0] sel);
        bit ok;
        ok = 0;
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_adr = adr;
        cmd_dat = dat;
        cmd_sel = sel;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        if (!ok) check("cmd_accept_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            check("rsp_wait", sb_q.size(), 0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_adr = '0;
        cmd_dat = '0;
        cmd_sel = '0;
        rsp_ready = 1'b1;
        dev_wait = 0;
        dev_never = 0;
        dev_err = 0;
        dev_rdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_dat", rsp_dat, 0);
        check("rst_rsp_status", 32'(rsp_status), 0);
        check("rst_cyc", wb.cyc, 0);
        check("rst_stb", wb.stb, 0);
        check("rst_adr", wb.adr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write to LED register
        push(32'h0, WB_OK, 1);
        send(1'b1, 32'h0, 32'hA5, 4'hF);
        check("wr_cyc_c1", wb.cyc, 1);
        check("wr_stb_c1", wb.stb, 1);
        check("wr_we_c1", wb.we, 1);
        check("wr_dat_c1", wb.dat_w, 32'hA5);
        @(posedge clk);
        #1;
        check("wr_rsp_valid_c2", rsp_valid, 1);
        wait_rsp();
        check("led_value", led, 32'hA5);

        // Read with 3 wait states
        dev_wait = 3;
        dev_rdata = 32'hDEADBEEF;
        push(32'hDEADBEEF, WB_OK, 4);
        send(1'b0, 32'h4, 32'h0, 4'hF);
        wait_rsp();

        // Device never acks: timeout after 8 cycles
        dev_never = 1;
        push(32'h0, WB_TIMEOUT, TO);
        send(1'b0, 32'h8, 32'h0, 4'hF);
        wait_rsp();
        check("to_cmd_ready_back", cmd_ready, 1);
        dev_never = 0;

        // ack and err together on 2nd bus cycle
        dev_wait = 5;
        dev_err = 1;
        push(32'h0, WB_ERR, 2);
        send(1'b0, 32'hC, 32'h0, 4'hF);
        wait_rsp();
        dev_err = 0;

        // Response back-pressure with a waiting command
        dev_wait = 0;
        dev_rdata = 32'h12345678;
        rsp_ready = 1'b0;
        push(32'h12345678, WB_OK, 1);
        send(1'b0, 32'h10, 32'h0, 4'hF);
        cmd_valid = 1'b1;
        cmd_we = 1'b1;
        cmd_adr = 32'h20;
        cmd_dat = 32'h5A;
        cmd_sel = 4'h1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_dat", rsp_dat, 32'h12345678);
            check("bp_cyc", wb.cyc, 0);
        end
        @(posedge clk);
        #1;
        push(32'h0, WB_OK, 1);
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cmd_ready) seen = 1;
        end
        check("bp_next_accept", seen, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp();
        check("bp_led", led, 32'h5A);

        // Reset in the 2nd cycle of a waited read
        dev_wait = 3;
        send(1'b0, 32'h30, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", wb.cyc, 0);
        check("mid_rst_stb", wb.stb, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("mid_rst_no_rsp", seen, 0);

        // Recovery: write after reset
        dev_wait = 0;
        push(32'h0, WB_OK, 1);
        send(1'b1, 32'h0, 32'h0000_3C00, 4'h2);
        wait_rsp();
        check("recover_led", led, 32'h0000_3C00);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
